// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises the raw lines, assembles and
// checks 11-bit frames, and queues good scancode bytes in a small FIFO.
module ps2_frame_rx #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          fall;
  logic          bit_in;

  logic [3:0]    bit_cnt;
  logic [9:0]    shift_reg;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  logic [10:0]   frame;
  logic          frame_done;
  logic          frame_good;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Line synchronisers; idle-high reset value so a released reset never looks like a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall   = (clk_sync[2:1] == 2'b10);
  assign bit_in = data_sync[1];

  // The ten earlier bits live in shift_reg; the bit arriving on the final fall completes the frame.
  assign frame      = {bit_in, shift_reg};
  assign frame_done = fall && (bit_cnt == 4'd10);
  assign frame_good = (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);

  assign timeout = (bit_cnt != 4'd0) && (to_cnt == TO_LAST) && !fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 4'd0;
      shift_reg <= 10'd0;
    end else if (fall) begin
      shift_reg <= {bit_in, shift_reg[9:1]};
      bit_cnt   <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
    end else if (timeout) begin
      bit_cnt <= 4'd0;
    end
  end

  // Saturating idle counter; only runs while a frame is partially received.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (fall || (bit_cnt == 4'd0)) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LAST) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && !nextdata_n;
  assign push  = frame_done && frame_good && (!full || pop);
  assign drop  = frame_done && frame_good && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'd0;
      end
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= frame[8:1];
        wptr              <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Overflow stays up until the consumer drains at least one byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (pop) begin
        overflow <= 1'b0;
      end
      frame_err <= frame_done && !frame_good;
    end
  end

  assign data  = mem[rptr[AW-1:0]];
  assign ready = !empty;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: stimulus queues expected bytes, a monitor
// checks each popped byte and every frame_err pulse.
module tb_ps2_frame_rx;

  localparam int DEPTH       = 8;
  localparam int TIMEOUT_CYC = 25000;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int         compared;
  int         mismatched;
  logic [7:0] model_q[$];
  logic       exp_ovf;
  int         exp_errs;
  int         seen_errs;
  logic       prev_err;

  ps2_frame_rx #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_parity);
    return {1'b1, (~^b) ^ bad_parity, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = frame[i];
      repeat (5) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (10) @(posedge clk);
      #1 ps2_clk = 1'b1;
      repeat (5) @(posedge clk);
    end
    #1 ps2_data = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  // Sends one full frame and records what the receiver should do with it.
  task automatic applyStimulus(input logic [7:0] b, input bit bad_parity);
    if (bad_parity) begin
      exp_errs++;
    end else if (model_q.size() < DEPTH) begin
      model_q.push_back(b);
    end else begin
      exp_ovf = 1'b1;
    end
    send_bits(make_frame(b, bad_parity), 11);
  endtask

  task automatic pop_byte();
    @(posedge clk); #1 nextdata_n = 1'b0;
    @(posedge clk); #1 nextdata_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    checkOutput({tag, "_ready"}, {7'd0, ready}, {7'd0, model_q.size() != 0});
    checkOutput({tag, "_overflow"}, {7'd0, overflow}, {7'd0, exp_ovf});
    if (model_q.size() != 0) checkOutput({tag, "_data"}, data, model_q[0]);
    checkOutput({tag, "_errs"}, 8'(seen_errs), 8'(exp_errs));
  endtask

  // Monitor: consumes scoreboard entries on each accepted pop and tracks frame_err pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_err <= 1'b0;
    end else begin
      if (ready && !nextdata_n) begin
        if (model_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL pop_data: got %h, expected no byte", data);
        end else begin
          checkOutput("pop_data", data, model_q.pop_front());
          exp_ovf = 1'b0;
        end
      end
      if (frame_err) begin
        seen_errs++;
        if (prev_err) checkOutput("err_width", {7'd0, frame_err}, 8'd0);
      end
      prev_err <= frame_err;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_ovf    = 1'b0;
    exp_errs   = 0;
    seen_errs  = 0;
    rst        = 1'b1;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {7'd0, ready}, 8'd0);
    checkOutput("rst_data", data, 8'd0);
    checkOutput("rst_overflow", {7'd0, overflow}, 8'd0);
    checkOutput("rst_frame_err", {7'd0, frame_err}, 8'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] test 1: single 0x1C");
    applyStimulus(8'h1C, 1'b0);
    check_state("t1");
    pop_byte();
    check_state("t1_after_pop");

    $display("[TB] test 2: F0 then 1C");
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h1C, 1'b0);
    check_state("t2");
    pop_byte();
    check_state("t2_pop1");
    pop_byte();
    check_state("t2_pop2");

    $display("[TB] test 3: bad parity");
    applyStimulus(8'h1C, 1'b1);
    check_state("t3");

    $display("[TB] test 4: overflow");
    for (int i = 1; i <= DEPTH + 1; i++) applyStimulus(8'(i), 1'b0);
    check_state("t4_full");
    checkOutput("t4_ovf_set", {7'd0, overflow}, 8'd1);
    checkOutput("t4_head", data, 8'h01);
    pop_byte();
    check_state("t4_pop");
    checkOutput("t4_next", data, 8'h02);
    for (int i = 0; i < DEPTH - 1; i++) pop_byte();
    check_state("t4_drained");
    pop_byte();
    check_state("t4_empty_pop");

    $display("[TB] test 5: timeout resync");
    send_bits(make_frame(8'hA5, 1'b0), 5);
    repeat (30000) @(posedge clk);
    applyStimulus(8'h5A, 1'b0);
    check_state("t5");
    checkOutput("t5_data", data, 8'h5A);
    pop_byte();
    check_state("t5_pop");

    $display("[TB] test 6: reset mid-frame");
    send_bits(make_frame(8'h77, 1'b0), 7);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_q.delete();
    exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    check_state("t6_reset");
    applyStimulus(8'h29, 1'b0);
    check_state("t6");
    checkOutput("t6_data", data, 8'h29);
    pop_byte();
    check_state("t6_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
